// File: rtl/gol_frame_scheduler_if.sv
// Engine and cell-memory port bundle for the life frame scheduler.
// master = scheduler side, slave = engine/RAM side.
interface gol_frame_scheduler_if #(
    parameter int ADDR_W = 12
);
    logic              eng_req;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_wdata;
    logic              eng_gnt;
    logic              eng_rdata;
    logic              eng_rvalid;

    logic [ADDR_W:0]   mem_addr;
    logic              mem_we;
    logic              mem_wdata;
    logic              mem_rdata;

    modport master (
        input  eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
        output eng_gnt, eng_rdata, eng_rvalid, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
        input  eng_gnt, eng_rdata, eng_rvalid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/gol_frame_scheduler.sv
// Paces life generations to vertical blank and shares the single-port,
// double-buffered cell RAM between scanout and the update engine.
//
// state       | meaning
// S_IDLE      | waiting for a frame tick that starts a generation
// S_START     | one-cycle gen_start pulse to the engine
// S_RUN       | engine computing; owns the port during blanking
// S_SWAP_WAIT | next page complete; flip display page on next tick
module gol_frame_scheduler #(
    parameter int ADDR_W         = 12,
    parameter int FRAMES_PER_GEN = 30,
    parameter int VB_LINE        = 511
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        i_counterY,
    input  logic              i_displayZone,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_rdata,
    output logic              o_gen_start,
    input  logic              i_gen_done,
    input  logic              i_run,
    input  logic              i_step,
    output logic              o_disp_page,
    output logic [15:0]       o_gen_count,
    output logic              o_busy,
    output logic              o_overrun,
    gol_frame_scheduler_if.master bus
);
    localparam int         FC_W    = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_GEN - 1);
    localparam logic [9:0] VB_Y    = 10'(VB_LINE);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_SWAP_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [9:0]        r_prev_y;
    logic [FC_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
    logic              r_step_pend, w_step_pend_nxt;
    logic              r_disp_page, w_disp_page_nxt;
    logic [15:0]       r_gen_count, w_gen_count_nxt;
    logic              r_overrun, w_overrun_nxt;
    logic              r_eng_rvalid;
    logic              w_tick;
    logic              w_consume;
    logic              w_gnt;

    assign w_tick = (i_counterY == VB_Y) && (r_prev_y != VB_Y);

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_disp_page_nxt = r_disp_page;
        w_gen_count_nxt = r_gen_count;
        w_overrun_nxt   = r_overrun;
        w_consume       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    if (r_step_pend || (i_run && r_frame_cnt == FC_LAST)) begin
                        w_state_nxt     = S_START;
                        w_frame_cnt_nxt = '0;
                        w_consume       = 1'b1;
                    end else if (i_run) begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            S_START: w_state_nxt = S_RUN;
            S_RUN: begin
                // a tick coinciding with done is spent; the swap waits for the next one
                if (i_gen_done) begin
                    w_state_nxt = S_SWAP_WAIT;
                end else if (w_tick) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            S_SWAP_WAIT: begin
                if (w_tick) begin
                    w_disp_page_nxt = ~r_disp_page;
                    w_gen_count_nxt = r_gen_count + 16'd1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // a step arriving on the consuming tick is kept for the following one
        w_step_pend_nxt = (r_step_pend & ~w_consume) | i_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prev_y     <= '0;
            r_frame_cnt  <= '0;
            r_step_pend  <= 1'b0;
            r_disp_page  <= 1'b0;
            r_gen_count  <= '0;
            r_overrun    <= 1'b0;
            r_eng_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_y     <= i_counterY;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_step_pend  <= w_step_pend_nxt;
            r_disp_page  <= w_disp_page_nxt;
            r_gen_count  <= w_gen_count_nxt;
            r_overrun    <= w_overrun_nxt;
            r_eng_rvalid <= w_gnt & ~bus.eng_we;
        end
    end

    assign w_gnt = bus.eng_req & ~i_displayZone & (r_state == S_RUN);

    // engine writes always target the hidden page, reads the shown one
    always_comb begin
        bus.mem_addr  = {r_disp_page, i_disp_addr};
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 1'b0;
        if (w_gnt) begin
            bus.mem_addr  = {bus.eng_we ? ~r_disp_page : r_disp_page, bus.eng_addr};
            bus.mem_we    = bus.eng_we;
            bus.mem_wdata = bus.eng_wdata;
        end
    end

    assign bus.eng_gnt    = w_gnt;
    assign bus.eng_rdata  = bus.mem_rdata;
    assign bus.eng_rvalid = r_eng_rvalid;
    assign o_disp_rdata   = bus.mem_rdata;
    assign o_gen_start    = (r_state == S_START);
    assign o_busy         = (r_state != S_IDLE);
    assign o_disp_page    = r_disp_page;
    assign o_gen_count    = r_gen_count;
    assign o_overrun      = r_overrun;
endmodule
